gen_dec_pipe: RTL and testbench
===============================

# gen_dec_pipe

Registered binary-to-one-hot decoder with a valid/ready handshake on both sides. It is the inverse of the library's one-hot encoder: it turns an index back into a one-hot select vector. Typical uses are driving grant, write-enable or mux-select vectors from a pipelined index stream. A 2-entry skid buffer gives full throughput with registered `in_rdy`. Indices outside `0..DAT_OUT_W-1` are flagged per transfer and counted.

## Interface
Parameters:
- `DAT_OUT_W`, 4: one-hot output width in bits; legal range is ≥2.
- `ERR_CNT_W`, 8: width of the out-of-range event counter.
- `DAT_IN_W`, localparam `$clog2(DAT_OUT_W)`: width of the binary index input.

Ports:
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: **synchronous, active-high** reset.
- `in_vld`, in, 1: input index valid.
- `in_rdy`, out, 1: block can accept; driven directly from a register.
- `dat_in`, in, `DAT_IN_W`: binary index.
- `out_vld`, out, 1: output valid.
- `out_rdy`, in, 1: downstream accepts.
- `dat_out`, out, `DAT_OUT_W`: one-hot vector, `dat_out[dat_in]=1`.
- `out_err`, out, 1: the current output came from an out-of-range index.
- `err_clr`, in, 1: synchronous clear of `err_cnt`.
- `err_cnt`, out, `ERR_CNT_W`: saturating count of accepted out-of-range indices.

## Operation
- **Transfers:** input transfer is `in_vld && in_rdy`; output transfer is `out_vld && out_rdy`.
- **Decode at acceptance:**
  - In range (`dat_in < DAT_OUT_W`): `dat_out` has exactly bit `dat_in` set; `out_err=0`.
  - Out of range (only possible when `DAT_OUT_W` is not a power of 2): `dat_out` is all zeros; `out_err=1`.
- **Storage:** a main output register plus one skid register. Each entry holds `{dat_out, out_err}`.
- **State machine** (occupancy):
  - EMPTY: `out_vld=0`, `in_rdy=1`.
  - ONE: main register full, `out_vld=1`, `in_rdy=1`.
  - TWO: main and skid both full, `out_vld=1`, `in_rdy=0`.
- **Transitions:**
  - EMPTY + input transfer → ONE.
  - ONE + input transfer, no output transfer → TWO; the new entry goes to skid.
  - ONE + output transfer, no input transfer → EMPTY.
  - ONE + both transfers → ONE; the new entry goes to main.
  - TWO + output transfer → ONE; skid moves to main. No input transfer is possible in TWO.
- **Ordering:** strictly FIFO. No entry is dropped or duplicated.
- **Output stability:** `dat_out`/`out_err` hold stable while `out_vld && !out_rdy`.
- **Error counter:**
  - Increments by 1 on each input transfer with an out-of-range index.
  - Saturates at all-ones and does not wrap.
  - `err_clr` alone → 0.
  - `err_clr` together with an increment in the same cycle → 1, so the event is not lost.

## Timing
- **Latency:** an input transfer in cycle N appears on the output at cycle N+1 when the block was EMPTY.
- **Throughput:** one transfer per cycle sustained while `out_rdy=1`.
- **`in_rdy` timing:**
  - Registered; it is a function of next occupancy only, with no combinational path from `out_rdy`.
  - It drops the cycle after entering TWO and rises the cycle after leaving TWO.
- **During reset (cycles with `rst=1`):**
  - Outputs go to `out_vld=0`, `dat_out=0`, `out_err=0`, `in_rdy=0`, `err_cnt=0`, state EMPTY.
  - `in_rdy` becomes 1 on the first cycle after `rst` deasserts.
- **Reset mid-operation:** all entries are discarded; no output transfer occurs in a cycle where `rst=1`.
- **Input independence:** `in_vld` and `dat_in` are ignored when `in_rdy=0`.

## Structure
- Shared package `gen_common_pkg` holds the occupancy enum (`EMPTY`, `ONE`, `TWO`), 2-bit.
- The decode is a single combinational function inside this block.
- One sub-module is natural: `gen_skid_buf`.
  - Parameterised payload width, here `DAT_OUT_W+1`.
  - Contains the state machine, the main and skid registers, and registered ready.
  - Reusable elsewhere in gen_common.
- The error counter stays in the top block.

## Test plan
- **Reset:** hold `rst` 3 cycles with `in_vld=1` → `out_vld=0`, `in_rdy=0`, `err_cnt=0` throughout; `in_rdy=1` on the cycle after release.
- **Streaming:** `DAT_OUT_W=4`, `out_rdy=1`, indices 0,1,2,3 back-to-back → `dat_out` 0001, 0010, 0100, 1000 on consecutive cycles starting one cycle after the first accept; `out_err=0`.
- **Backpressure:** `out_rdy=0`, send 2 and 1 → `in_rdy` falls after the second accept; `dat_out=0100` holds. Raise `out_rdy` → 0100 then 0010; `in_rdy` rises; no loss.
- **Out of range:** `DAT_OUT_W=5`, send index 7 → `dat_out=00000`, `out_err=1`, `err_cnt=1`. Send index 4 → `dat_out=10000`, `out_err=0`.
- **Counter saturation:** `ERR_CNT_W=2`, five out-of-range indices → `err_cnt` 1, 2, 3, 3, 3. Then `err_clr` plus one more in the same cycle → `err_cnt=1`.
- **Random stall:** random `in_vld`/`out_rdy` for 10k cycles against a reference FIFO model → output order and values match; `in_rdy` never toggles combinationally with `out_rdy`.

Source files
------------

// File: rtl/gen_common_pkg.sv
// Shared types for the gen_common block library.
package gen_common_pkg;

  // Occupancy of a two-entry main/skid output stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/gen_skid_buf.sv
// Two-entry skid buffer: main output register plus one skid register.
// in_rdy is registered and depends only on the next occupancy, so there is
// no combinational path from out_rdy back to in_rdy.
module gen_skid_buf
  import gen_common_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  occ_e         state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = out_vld && out_rdy;
  assign out_data = main_q;

  // Occupancy state machine; moves entries between input, skid and main
  // and registers both handshake outputs from the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_rdy <= 1'b1;
          if (in_xfer) begin
            main_q  <= in_data;
            out_vld <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              skid_q <= in_data;
              in_rdy <= 1'b0;
              state  <= TWO;
            end
            2'b01: begin
              out_vld <= 1'b0;
              in_rdy  <= 1'b1;
              state   <= EMPTY;
            end
            2'b11: begin
              main_q <= in_data;
              in_rdy <= 1'b1;
            end
            default: begin
              in_rdy <= 1'b1;
            end
          endcase
        end
        TWO: begin
          if (out_xfer) begin
            main_q <= skid_q;
            in_rdy <= 1'b1;
            state  <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          in_rdy  <= 1'b1;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gen_dec_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides.
// Out-of-range indices produce an all-zero vector with out_err set and are
// counted in a saturating error counter.
module gen_dec_pipe
  import gen_common_pkg::*;
#(
  parameter  int DAT_OUT_W = 4,
  parameter  int ERR_CNT_W = 8,
  localparam int DAT_IN_W  = $clog2(DAT_OUT_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [DAT_IN_W-1:0]  dat_in,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [DAT_OUT_W-1:0] dat_out,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Widened limit so the range test also works when DAT_OUT_W is a power of 2.
  localparam logic [DAT_IN_W:0] IDX_LIMIT = (DAT_IN_W + 1)'(DAT_OUT_W);

  // Payload layout is {one-hot vector, error flag}.
  function automatic logic [DAT_OUT_W:0] decode(input logic [DAT_IN_W-1:0] idx);
    logic [DAT_OUT_W-1:0] onehot;
    logic                 err;
    onehot = '0;
    err    = 1'b1;
    if ({1'b0, idx} < IDX_LIMIT) begin
      onehot[idx] = 1'b1;
      err         = 1'b0;
    end
    return {onehot, err};
  endfunction

  logic [DAT_OUT_W:0] in_payload;
  logic [DAT_OUT_W:0] out_payload;
  logic               err_event;

  assign in_payload = decode(dat_in);
  assign err_event  = in_vld && in_rdy && in_payload[0];
  assign dat_out    = out_payload[DAT_OUT_W:1];
  assign out_err    = out_payload[0];

  gen_skid_buf #(
    .W(DAT_OUT_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_payload),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_payload)
  );

  // Saturating error counter; a clear coinciding with a new event keeps that event.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= err_event ? ERR_CNT_W'(1) : '0;
    end else if (err_event && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gen_dec_pipe.sv
// Directed self-checking bench for gen_dec_pipe: a 4-wide instance for
// streaming, backpressure and random stalls, and a 5-wide instance with a
// 2-bit error counter for out-of-range handling and saturation.
module tb_gen_dec_pipe;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_vld4, in_rdy4, out_vld4, out_rdy4, out_err4, err_clr4;
  logic [1:0] dat_in4;
  logic [3:0] dat_out4;
  logic [7:0] err_cnt4;

  logic       in_vld5, in_rdy5, out_vld5, out_rdy5, out_err5, err_clr5;
  logic [2:0] dat_in5;
  logic [4:0] dat_out5;
  logic [1:0] err_cnt5;

  int checks = 0;
  int errors = 0;

  logic [3:0] ref_q[$];
  logic [3:0] exp_stream[4];
  logic [1:0] exp_cnt[5];
  logic [2:0] oor_idx[5];

  always #5 clk = ~clk;

  gen_dec_pipe #(.DAT_OUT_W(4), .ERR_CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .in_vld(in_vld4), .in_rdy(in_rdy4), .dat_in(dat_in4),
    .out_vld(out_vld4), .out_rdy(out_rdy4), .dat_out(dat_out4), .out_err(out_err4),
    .err_clr(err_clr4), .err_cnt(err_cnt4)
  );

  gen_dec_pipe #(.DAT_OUT_W(5), .ERR_CNT_W(2)) u5 (
    .clk(clk), .rst(rst), .in_vld(in_vld5), .in_rdy(in_rdy5), .dat_in(dat_in5),
    .out_vld(out_vld5), .out_rdy(out_rdy5), .dat_out(dat_out5), .out_err(out_err5),
    .err_clr(err_clr5), .err_cnt(err_cnt5)
  );

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_stream = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    oor_idx    = '{3'd5, 3'd6, 3'd7, 3'd5, 3'd7};
    exp_cnt    = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset held three cycles with valid inputs present.
    rst = 1'b1;
    in_vld4 = 1'b1; dat_in4 = 2'd1; out_rdy4 = 1'b1; err_clr4 = 1'b0;
    in_vld5 = 1'b1; dat_in5 = 3'd7; out_rdy5 = 1'b1; err_clr5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_out_vld", {31'd0, out_vld4}, 32'd0);
      checkOutput("rst_in_rdy", {31'd0, in_rdy4}, 32'd0);
      checkOutput("rst_dat_out", {28'd0, dat_out4}, 32'd0);
      checkOutput("rst_err_cnt5", {30'd0, err_cnt5}, 32'd0);
      checkOutput("rst_in_rdy5", {31'd0, in_rdy5}, 32'd0);
    end
    rst = 1'b0; in_vld4 = 1'b0; in_vld5 = 1'b0;
    step();
    checkOutput("rel_in_rdy", {31'd0, in_rdy4}, 32'd1);
    checkOutput("rel_out_vld", {31'd0, out_vld4}, 32'd0);
    checkOutput("rel_err_cnt5", {30'd0, err_cnt5}, 32'd0);

    // Back-to-back streaming with the sink always ready.
    for (int i = 0; i < 4; i++) begin
      in_vld4 = 1'b1; dat_in4 = 2'(i);
      step();
      checkOutput("stream_vld", {31'd0, out_vld4}, 32'd1);
      checkOutput("stream_dat", {28'd0, dat_out4}, {28'd0, exp_stream[i]});
      checkOutput("stream_err", {31'd0, out_err4}, 32'd0);
      checkOutput("stream_rdy", {31'd0, in_rdy4}, 32'd1);
    end
    in_vld4 = 1'b0;
    step();
    checkOutput("stream_drain", {31'd0, out_vld4}, 32'd0);

    // Backpressure: fill main and skid, then release.
    out_rdy4 = 1'b0; in_vld4 = 1'b1; dat_in4 = 2'd2;
    step();
    checkOutput("bp_first_dat", {28'd0, dat_out4}, 32'h4);
    checkOutput("bp_first_rdy", {31'd0, in_rdy4}, 32'd1);
    dat_in4 = 2'd1;
    step();
    checkOutput("bp_full_rdy", {31'd0, in_rdy4}, 32'd0);
    checkOutput("bp_full_dat", {28'd0, dat_out4}, 32'h4);
    dat_in4 = 2'd3;
    step();
    checkOutput("bp_hold_dat", {28'd0, dat_out4}, 32'h4);
    checkOutput("bp_hold_rdy", {31'd0, in_rdy4}, 32'd0);
    checkOutput("bp_hold_vld", {31'd0, out_vld4}, 32'd1);
    in_vld4 = 1'b0; out_rdy4 = 1'b1;
    step();
    checkOutput("bp_skid_dat", {28'd0, dat_out4}, 32'h2);
    checkOutput("bp_skid_rdy", {31'd0, in_rdy4}, 32'd1);
    checkOutput("bp_skid_vld", {31'd0, out_vld4}, 32'd1);
    step();
    checkOutput("bp_empty_vld", {31'd0, out_vld4}, 32'd0);

    // Out-of-range index on the 5-wide instance.
    in_vld5 = 1'b1; dat_in5 = 3'd7;
    step();
    checkOutput("oor_dat", {27'd0, dat_out5}, 32'd0);
    checkOutput("oor_err", {31'd0, out_err5}, 32'd1);
    checkOutput("oor_cnt", {30'd0, err_cnt5}, 32'd1);
    dat_in5 = 3'd4;
    step();
    checkOutput("top_dat", {27'd0, dat_out5}, 32'h10);
    checkOutput("top_err", {31'd0, out_err5}, 32'd0);
    checkOutput("top_cnt", {30'd0, err_cnt5}, 32'd1);
    dat_in5 = 3'd0;
    step();
    checkOutput("zero_dat", {27'd0, dat_out5}, 32'h01);

    // Saturation: the 7 above was the first of five out-of-range indices.
    for (int i = 1; i < 5; i++) begin
      dat_in5 = oor_idx[i];
      step();
      checkOutput("sat_cnt", {30'd0, err_cnt5}, {30'd0, exp_cnt[i]});
      checkOutput("sat_err", {31'd0, out_err5}, 32'd1);
    end
    err_clr5 = 1'b1; dat_in5 = 3'd6;
    step();
    checkOutput("clr_inc_cnt", {30'd0, err_cnt5}, 32'd1);
    in_vld5 = 1'b0;
    step();
    checkOutput("clr_only_cnt", {30'd0, err_cnt5}, 32'd0);
    err_clr5 = 1'b0;
    step();
    checkOutput("idle_cnt", {30'd0, err_cnt5}, 32'd0);

    // Random stalls against a reference FIFO model.
    ref_q.delete();
    for (int n = 0; n < 10000; n++) begin
      in_vld4  = 1'($urandom_range(0, 1));
      out_rdy4 = 1'($urandom_range(0, 3) != 0);
      dat_in4  = 2'($urandom_range(0, 3));
      if (in_rdy4 !== (ref_q.size() < 2)) begin
        checkOutput("rnd_in_rdy", {31'd0, in_rdy4}, {31'd0, ref_q.size() < 2});
      end
      if (out_vld4 !== (ref_q.size() != 0)) begin
        checkOutput("rnd_out_vld", {31'd0, out_vld4}, {31'd0, ref_q.size() != 0});
      end
      if (out_vld4 && out_rdy4 && ref_q.size() != 0) begin
        checkOutput("rnd_dat", {28'd0, dat_out4}, {28'd0, ref_q[0]});
        checkOutput("rnd_err", {31'd0, out_err4}, 32'd0);
        void'(ref_q.pop_front());
      end
      if (in_vld4 && in_rdy4) begin
        ref_q.push_back(4'b0001 << dat_in4);
      end
      step();
    end
    checkOutput("rnd_final_vld", {31'd0, out_vld4}, {31'd0, ref_q.size() != 0});

    // Reset mid-operation discards stored entries.
    in_vld4 = 1'b1; out_rdy4 = 1'b0; dat_in4 = 2'd3;
    step();
    step();
    out_rdy4 = 1'b1; rst = 1'b1;
    step();
    checkOutput("mid_rst_vld", {31'd0, out_vld4}, 32'd0);
    checkOutput("mid_rst_dat", {28'd0, dat_out4}, 32'd0);
    checkOutput("mid_rst_rdy", {31'd0, in_rdy4}, 32'd0);
    rst = 1'b0; in_vld4 = 1'b0;
    step();
    checkOutput("mid_rel_rdy", {31'd0, in_rdy4}, 32'd1);
    checkOutput("mid_rel_vld", {31'd0, out_vld4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
